// File: rtl/aes_pkg.sv
// Shared definitions for the AES key-schedule sequencer: state encoding,
// round-count helpers and GF(2^8) doubling.
package aes_pkg;

  localparam int unsigned AES_IDX_W = 6;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } aes_ks_state_e;

  function automatic int unsigned aes_nr(input int unsigned nk);
    return nk + 6;
  endfunction

  function automatic int unsigned aes_last_idx(input int unsigned nk);
    return 4 * (aes_nr(nk) + 1) - 1;
  endfunction

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_sched_seq.sv
// Key-schedule sequencer: walks expanded-key word indices NK..4*(NR+1)-1 and
// presents the round constant and transform type per word over valid/ready.
module aes_key_sched_seq
  import aes_pkg::*;
#(
  parameter int unsigned NK    = 4,
  parameter int unsigned IDX_W = AES_IDX_W
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_fStart,
  input  logic             i_fAbort,
  input  logic             i_Ready,
  output logic             o_Valid,
  output logic [IDX_W-1:0] o_WordIdx,
  output logic [3:0]       o_Round,
  output logic [7:0]       o_Rcon,
  output logic             o_fRotSub,
  output logic             o_fSubOnly,
  output logic             o_fBusy,
  output logic             o_fDone
);

  if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
    $error("aes_key_sched_seq: NK must be 4, 6 or 8");
  end
  if (IDX_W < 6) begin : g_bad_idx_w
    $error("aes_key_sched_seq: IDX_W must hold index 59");
  end

  localparam logic [IDX_W-1:0] FirstIdx = IDX_W'(NK);
  localparam logic [IDX_W-1:0] LastIdx  = IDX_W'(aes_last_idx(NK));
  localparam logic [2:0]       PhaseMax = 3'(NK - 1);

  aes_ks_state_e    state_q;
  logic [IDX_W-1:0] idx_q;
  logic [2:0]       phase_q;
  logic [7:0]       rcon_q;
  logic             run;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      phase_q <= '0;
      rcon_q  <= 8'h01;
    end else if (i_fAbort) begin
      state_q <= StIdle;
      idx_q   <= '0;
      phase_q <= '0;
      rcon_q  <= 8'h01;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_fStart) begin
            state_q <= StRun;
            idx_q   <= FirstIdx;
            phase_q <= '0;
            rcon_q  <= 8'h01;
          end
        end
        StRun: begin
          if (i_Ready) begin
            if (idx_q == LastIdx) begin
              // Counters are reinitialised on the final transfer so DONE sees clean state.
              state_q <= StDone;
              idx_q   <= '0;
              phase_q <= '0;
              rcon_q  <= 8'h01;
            end else begin
              idx_q   <= idx_q + 1'b1;
              phase_q <= (phase_q == PhaseMax) ? 3'd0 : phase_q + 3'd1;
              if (phase_q == 3'd0) begin
                rcon_q <= xtime(rcon_q);
              end
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          idx_q   <= '0;
          phase_q <= '0;
          rcon_q  <= 8'h01;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs decode only flop state, so they hold during stalls and clear with reset.
  assign run        = (state_q == StRun);
  assign o_Valid    = run;
  assign o_fBusy    = run;
  assign o_fDone    = (state_q == StDone);
  assign o_WordIdx  = run ? idx_q : '0;
  assign o_Round    = 4'(o_WordIdx >> 2);
  assign o_fRotSub  = run && (phase_q == 3'd0);
  assign o_fSubOnly = run && (NK == 8) && (phase_q == 3'd4);
  assign o_Rcon     = o_fRotSub ? rcon_q : 8'h00;

endmodule
